layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
- Time-multiplexes one multiply-accumulate plus sigmoid-ROM datapath across all N_OUT neurons of a fully connected layer.
- Loads an input vector over a valid/ready stream, fetches bias and weights from an external synchronous weight ROM, and accumulates the weighted sum.
- Saturates the sum into a sigmoid ROM address, waits for the ROM, then emits one 8-bit activation per neuron on a valid/ready output stream.
- Sits between the input-vector source and the next layer; replaces N_OUT parallel neuron instances.

Parameters:
- N_IN, 3, inputs per neuron (>=1)
- N_OUT, 4, neurons in layer (>=1)
- SIG_LAT, 1, sigmoid ROM read latency in cycles (>=1)
- WA_W, 8, weight ROM address width; must hold N_OUT*(N_IN+1)-1

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- in_valid  in  1  input word valid
- in_ready  out  1  high only in LOAD
- in_data  in  32  signed input x_k, k=0..N_IN-1 in order
- w_addr  out  WA_W  weight ROM address
- w_data  in  32  signed ROM data, valid 1 cycle after w_addr
- sig_addr  out  14  sigmoid ROM address
- sig_q  in  8  sigmoid ROM data, valid SIG_LAT cycles after sig_addr
- out_valid  out  1  activation valid
- out_ready  in  1  downstream accept
- out_data  out  8  activation (sig_q captured)
- out_idx  out  8  neuron index of out_data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last neuron is accepted

Behaviour:
- Reset: state=IDLE. in_ready, out_valid, done, busy = 0. w_addr, sig_addr, out_data, out_idx, accumulator, neuron and word counters = 0. Input buffer contents are don't-care.
- ROM layout: bias of neuron j at address j*(N_IN+1); weight w_k at j*(N_IN+1)+1+k.
- IDLE: on start=1, go to LOAD. Any in_valid seen in IDLE is ignored (in_ready=0).
- LOAD:
  - in_ready=1. Each cycle with in_valid&in_ready stores in_data into buf[cnt] and increments cnt.
  - After N_IN accepts, clear j=0 and go to MAC.
- MAC:
  - Issue w_addr = j*(N_IN+1)+t for t=0..N_IN on consecutive cycles.
  - On the cycle after each issue: acc = w_data for t=0; otherwise acc += w_data*buf[t-1].
  - Product and sum are truncated to 32 bits, two's-complement wrap.
  - Phase takes exactly N_IN+2 cycles, then go to SAT.
- SAT (1 cycle): compute a16:
  - 0x0000 if acc < -32768
  - 0xFFFF if acc > 32767
  - otherwise acc[15:0]+32768, mod 2^16
  - Register sig_addr = a16[15:2]. Go to SIG_WAIT.
- SIG_WAIT: hold sig_addr for SIG_LAT cycles. On the final cycle capture out_data=sig_q and out_idx=j, then go to OUT.
- OUT:
  - out_valid=1; out_data and out_idx are held stable until out_valid&out_ready.
  - On accept: if j<N_OUT-1, increment j and go to MAC; else go to DONE.
  - out_valid deasserts the cycle after accept.
- DONE: done=1 for one cycle, then IDLE. A new start is accepted the following cycle.
- Latency per neuron with out_ready held high: N_IN+2 (MAC) + 1 (SAT) + SIG_LAT + 1 (OUT) cycles.
- start while busy: ignored; no restart.
- rst mid-operation: returns to IDLE with reset values the next cycle. A pending out_valid is dropped and done is not pulsed.
- Downstream backpressure: stalls only in OUT. No other state depends on out_ready.
- in_valid low in LOAD: wait indefinitely with no timeout.

Optional Feature:
- Macro LAYER_SEQ_STALL_CNT_EN.
- When defined, adds output port stall_cnt [31:0]:
  - cleared by rst and on start accepted in IDLE
  - increments each cycle out_valid=1 & out_ready=0
  - saturates at 0xFFFFFFFF and holds its value after done
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles mid-LOAD -> next cycle in_ready=0, busy=0, out_valid=0, done=0; a later start runs normally.
- Basic (N_IN=3, N_OUT=1, SIG_LAT=1): x=(1,2,3), bias=5, w=(10,20,30) -> acc=145, sig_addr=0x2024. ROM model q=addr[13:6] gives out_data=0x80, out_idx=0; done pulses 1 cycle after accept.
- Saturation: bias=0, w=(40000,0,0), x=(1,0,0) -> sig_addr=0x3FFF. Same with w1=-40000 -> sig_addr=0x0000. Boundary acc=32767 -> 0x3FFF; acc=-32768 -> 0x0000.
- Backpressure: N_OUT=2, hold out_ready=0 for 5 cycles in OUT for neuron 0 -> out_data/out_idx stable, no MAC address issued. Release -> neuron 1 w_addr sequence starts at 4. With the macro defined, stall_cnt=5.
- Start while busy / input ignore: pulse start and in_valid during MAC -> no state change, in_ready stays 0, results identical to the undisturbed run.
- Back-to-back layers: assert start on the cycle after done with a new x vector -> second run produces correct activations, and out_idx restarts at 0.

Source files
------------

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_sequencer
//  Description : Time-multiplexed fully connected layer. One MAC and one
//                sigmoid ROM lookup are shared across N_OUT neurons. Loads an
//                input vector, walks bias/weights from an external weight ROM,
//                saturates the sum into a sigmoid ROM address and streams one
//                8-bit activation per neuron.
//                Optional feature macro: LAYER_SEQ_STALL_CNT_EN adds the
//                stall_cnt output (cycles spent stalled by downstream).
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int N_IN    = 3,
    parameter int N_OUT   = 4,
    parameter int SIG_LAT = 1,
    parameter int WA_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    output logic [WA_W-1:0] w_addr,
    input  logic [31:0]     w_data,
    output logic [13:0]     sig_addr,
    input  logic [7:0]      sig_q,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [7:0]      out_idx,
    output logic            busy,
    output logic            done
`ifdef LAYER_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    // MAC step counter spans 0..N_IN+1; it also serves as the load word counter
    localparam int c_T_W = $clog2(N_IN + 2);
    localparam int c_S_W = (SIG_LAT > 1) ? $clog2(SIG_LAT) : 1;

    localparam logic [c_T_W-1:0] c_T_LAST       = c_T_W'(N_IN + 1);
    localparam logic [c_T_W-1:0] c_T_ISSUE_LAST = c_T_W'(N_IN);
    localparam logic [c_T_W-1:0] c_CNT_LAST     = c_T_W'(N_IN - 1);
    localparam logic [c_T_W-1:0] c_T_BIAS       = c_T_W'(1);
    localparam logic [c_S_W-1:0] c_S_LAST       = c_S_W'(SIG_LAT - 1);
    localparam logic [7:0]       c_J_LAST       = 8'(N_OUT - 1);
    localparam logic [WA_W-1:0]  c_STRIDE       = WA_W'(N_IN + 1);

    localparam logic signed [31:0] c_SAT_LO = -32'sd32768;
    localparam logic signed [31:0] c_SAT_HI = 32'sd32767;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_LOAD = 3'd1;
    localparam logic [2:0] c_S_MAC  = 3'd2;
    localparam logic [2:0] c_S_SAT  = 3'd3;
    localparam logic [2:0] c_S_SIGW = 3'd4;
    localparam logic [2:0] c_S_OUT  = 3'd5;
    localparam logic [2:0] c_S_DONE = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [31:0]         r_buf [0:N_IN-1];
    logic [c_T_W-1:0]    r_cnt;
    logic [c_T_W-1:0]    r_t;
    logic [c_S_W-1:0]    r_scnt;
    logic [7:0]          r_j;
    logic [WA_W-1:0]     r_base;
    logic [WA_W-1:0]     r_w_addr;
    logic signed [31:0]  r_acc;
    logic [13:0]         r_sig_addr;
    logic [7:0]          r_out_data;
    logic [7:0]          r_out_idx;
    logic signed [31:0]  w_x;
    logic signed [31:0]  w_prod;
    logic [13:0]         w_sig;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived handshake/status outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        busy        = (r_state != c_S_IDLE);
        case (r_state)
            c_S_IDLE: begin
                if (start) w_state_nxt = c_S_LOAD;
            end
            c_S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == c_CNT_LAST)) w_state_nxt = c_S_MAC;
            end
            c_S_MAC: begin
                if (r_t == c_T_LAST) w_state_nxt = c_S_SAT;
            end
            c_S_SAT: begin
                w_state_nxt = c_S_SIGW;
            end
            c_S_SIGW: begin
                if (r_scnt == c_S_LAST) w_state_nxt = c_S_OUT;
            end
            c_S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = (r_j == c_J_LAST) ? c_S_DONE : c_S_MAC;
                end
            end
            c_S_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Select the input word paired with the weight arriving this MAC cycle
    // (cycle t carries weight k = t-2; cycle 1 carries the bias)
    always_comb begin
        w_x = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (32'(r_t) == k + 2) w_x = r_buf[k];
        end
    end

    // 32-bit wrapping product, upper bits intentionally discarded
    assign w_prod = $signed(w_data) * w_x;

    // Saturate the sum to 16 bits, offset to unsigned, drop two LSBs
    always_comb begin
        if (r_acc < c_SAT_LO) begin
            w_sig = 14'h0000;
        end else if (r_acc > c_SAT_HI) begin
            w_sig = 14'h3FFF;
        end else begin
            w_sig = {~r_acc[15], r_acc[14:2]};
        end
    end

    // Input vector buffer; contents need no reset
    always_ff @(posedge clk) begin
        if ((r_state == c_S_LOAD) && in_valid) begin
            for (int k = 0; k < N_IN; k++) begin
                if (32'(r_cnt) == k) r_buf[k] <= in_data;
            end
        end
    end

    // Datapath: counters, weight address walk, accumulator, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_t        <= '0;
            r_scnt     <= '0;
            r_j        <= '0;
            r_base     <= '0;
            r_w_addr   <= '0;
            r_acc      <= '0;
            r_sig_addr <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
        end else begin
            case (r_state)
                c_S_LOAD: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt    <= '0;
                            r_j      <= '0;
                            r_base   <= '0;
                            r_w_addr <= '0;
                            r_t      <= '0;
                        end
                    end
                end
                c_S_MAC: begin
                    r_t <= r_t + 1'b1;
                    if (r_t < c_T_ISSUE_LAST) r_w_addr <= r_w_addr + 1'b1;
                    if (r_t == c_T_BIAS) begin
                        r_acc <= w_data;
                    end else if (r_t != '0) begin
                        r_acc <= r_acc + w_prod;
                    end
                end
                c_S_SAT: begin
                    r_sig_addr <= w_sig;
                    r_scnt     <= '0;
                end
                c_S_SIGW: begin
                    r_scnt <= r_scnt + 1'b1;
                    if (r_scnt == c_S_LAST) begin
                        r_out_data <= sig_q;
                        r_out_idx  <= r_j;
                    end
                end
                c_S_OUT: begin
                    if (out_ready && (r_j != c_J_LAST)) begin
                        r_j      <= r_j + 1'b1;
                        r_base   <= r_base + c_STRIDE;
                        r_w_addr <= r_base + c_STRIDE;
                        r_t      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The sigmoid address is presented combinationally during SAT so the ROM
    // latency is counted from SAT; it is then held from the register.
    assign sig_addr = (r_state == c_S_SAT) ? w_sig : r_sig_addr;
    assign w_addr   = r_w_addr;
    assign out_data = r_out_data;
    assign out_idx  = r_out_idx;

`ifdef LAYER_SEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where an activation is offered but not accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_S_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_S_OUT) && !out_ready &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
